// File: rtl/hazard_pkg.sv
// Shared encodings and helpers for the pipeline hazard controller.
// Used by hazard_controller and forward_unit (HAZARD_FWD_EN build).
package hazard_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_STALL    = 2'd1,
        ST_MEM_WAIT = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_t;

    // Register 0 is hard-wired, so it can never carry a dependency.
    function automatic logic reg_match(input logic [4:0] a, input logic [4:0] b);
        return (a != 5'd0) && (a == b);
    endfunction

endpackage

// File: rtl/forward_unit.sv
// EX-stage operand bypass select; MEM result wins over WB result.
// Instantiated by hazard_controller only when HAZARD_FWD_EN is defined.
module forward_unit
    import hazard_pkg::*;
(
    input  logic [4:0] EX_Rs,
    input  logic [4:0] EX_Rt,
    input  logic [4:0] MEM_WriteReg,
    input  logic       MEM_RegWrite,
    input  logic [4:0] WB_WriteReg,
    input  logic       WB_RegWrite,
    output logic [1:0] forward_a,
    output logic [1:0] forward_b
);

    function automatic logic [1:0] select_source(input logic [4:0] src);
        if (MEM_RegWrite && reg_match(MEM_WriteReg, src))
            return FWD_MEM;
        else if (WB_RegWrite && reg_match(WB_WriteReg, src))
            return FWD_WB;
        else
            return FWD_REG;
    endfunction

    always_comb begin
        forward_a = select_source(EX_Rs);
        forward_b = select_source(EX_Rt);
    end

endmodule

// File: rtl/hazard_controller.sv
// Central 5-stage pipeline sequencer: stalls, branch flushes, memory-wait freeze.
// Define HAZARD_FWD_EN for the forwarding build (load-use stall + bypass selects).
module hazard_controller
    import hazard_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int WAIT_W      = 8
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [4:0] ID_Rs,
    input  logic [4:0] ID_Rt,
    input  logic       ID_UsesRs,
    input  logic       ID_UsesRt,
    input  logic [4:0] EX_Rs,
    input  logic [4:0] EX_Rt,
    input  logic [4:0] EX_WriteReg,
    input  logic [4:0] MEM_WriteReg,
    input  logic [4:0] WB_WriteReg,
    input  logic       EX_RegWrite,
    input  logic       MEM_RegWrite,
    input  logic       WB_RegWrite,
    input  logic       EX_MemtoReg,
    input  logic       MEM_Branch,
    input  logic       MEM_zero,
    input  logic       MEM_MemReq,
    input  logic       MEM_Ready,
    output logic       PCSrc,
    output logic       PC_En,
    output logic       IF_ID_En,
    output logic       EX_MEM_En,
    output logic       IF_ID_Flush,
    output logic       ID_EX_Flush,
    output logic       EX_MEM_Flush,
    output logic       MEM_WB_Flush,
    output logic [1:0] ForwardA,
    output logic [1:0] ForwardB,
    output logic [1:0] State,
    output logic       MemErr
);

    localparam logic [WAIT_W-1:0] TIMEOUT_CNT = WAIT_W'(MEM_TIMEOUT);

    state_t            state_q;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_next;
    logic              mem_err;
    logic              memwait;
    logic              taken;
    logic              stall;
    logic [1:0]        fwd_a;
    logic [1:0]        fwd_b;

    assign memwait = MEM_MemReq & ~MEM_Ready;
    assign taken   = MEM_Branch & MEM_zero;

`ifdef HAZARD_FWD_EN
    assign stall = EX_RegWrite & EX_MemtoReg &
                   ((ID_UsesRs & reg_match(EX_WriteReg, ID_Rs)) |
                    (ID_UsesRt & reg_match(EX_WriteReg, ID_Rt)));

    forward_unit u_forward_unit (
        .EX_Rs        (EX_Rs),
        .EX_Rt        (EX_Rt),
        .MEM_WriteReg (MEM_WriteReg),
        .MEM_RegWrite (MEM_RegWrite),
        .WB_WriteReg  (WB_WriteReg),
        .WB_RegWrite  (WB_RegWrite),
        .forward_a    (fwd_a),
        .forward_b    (fwd_b)
    );
`else
    // Without bypassing, any in-flight producer in EX or MEM must drain first.
    assign stall = (ID_UsesRs & ((EX_RegWrite  & reg_match(EX_WriteReg,  ID_Rs)) |
                                 (MEM_RegWrite & reg_match(MEM_WriteReg, ID_Rs)))) |
                   (ID_UsesRt & ((EX_RegWrite  & reg_match(EX_WriteReg,  ID_Rt)) |
                                 (MEM_RegWrite & reg_match(MEM_WriteReg, ID_Rt))));
    assign fwd_a = FWD_REG;
    assign fwd_b = FWD_REG;

    logic unused_fwd_inputs;
    assign unused_fwd_inputs = ^{EX_Rs, EX_Rt, WB_WriteReg, WB_RegWrite, EX_MemtoReg};
`endif

    always_comb begin
        PCSrc        = 1'b0;
        PC_En        = 1'b1;
        IF_ID_En     = 1'b1;
        EX_MEM_En    = 1'b1;
        IF_ID_Flush  = 1'b0;
        ID_EX_Flush  = 1'b0;
        EX_MEM_Flush = 1'b0;
        MEM_WB_Flush = 1'b0;
        ForwardA     = fwd_a;
        ForwardB     = fwd_b;
        if (RST) begin
            PC_En        = 1'b0;
            IF_ID_En     = 1'b0;
            EX_MEM_En    = 1'b0;
            IF_ID_Flush  = 1'b1;
            ID_EX_Flush  = 1'b1;
            EX_MEM_Flush = 1'b1;
            MEM_WB_Flush = 1'b1;
            ForwardA     = FWD_REG;
            ForwardB     = FWD_REG;
        end else if (memwait) begin
            PC_En        = 1'b0;
            IF_ID_En     = 1'b0;
            EX_MEM_En    = 1'b0;
            MEM_WB_Flush = 1'b1;
        end else if (taken) begin
            PCSrc        = 1'b1;
            IF_ID_Flush  = 1'b1;
            ID_EX_Flush  = 1'b1;
            EX_MEM_Flush = 1'b1;
        end else if (stall) begin
            PC_En        = 1'b0;
            IF_ID_En     = 1'b0;
            ID_EX_Flush  = 1'b1;
        end
    end

    assign wait_next = (wait_cnt == TIMEOUT_CNT) ? wait_cnt : wait_cnt + 1'b1;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= ST_RUN;
            wait_cnt <= '0;
            mem_err  <= 1'b0;
        end else begin
            if (memwait)
                state_q <= ST_MEM_WAIT;
            else if (stall && !taken)
                state_q <= ST_STALL;
            else
                state_q <= ST_RUN;

            if (memwait) begin
                wait_cnt <= wait_next;
                if (wait_next == TIMEOUT_CNT)
                    mem_err <= 1'b1;
            end else begin
                wait_cnt <= '0;
            end
        end
    end

    assign State  = state_q;
    assign MemErr = mem_err;

endmodule
